hex_display_scanner: RTL and testbench

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

---
 rtl/hex_display_pkg.sv | 9 +
 rtl/scan_prescaler.sv | 26 ++
 rtl/hex_display_scanner.sv | 81 ++++++++
 tb/tb_hex_display_scanner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared defaults and types for the hex display scanner
package hex_display_pkg;

    localparam int NUM_DIGITS_DEF = 8;
    localparam int SCAN_DIV_DEF   = 50000;

    typedef logic [$clog2(NUM_DIGITS_DEF)-1:0] digit_idx_t;

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - free-running divider producing one tick per digit period
module scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] count;

    assign tick = (count == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - multiplexed hex digit scanner with frame-synchronous value update
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    output logic                    load_ready,
    input  logic                    blank_lz,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);

    logic                    tick;
    logic                    frame_start;
    logic                    accept;
    logic                    pend;
    logic                    blanked;
    logic [IW-1:0]           index;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] display;
    logic [NUM_DIGITS-1:0]   zero_from;

    scan_prescaler #(
        .SCAN_DIV(SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign frame_start = tick && (index == IW'(NUM_DIGITS - 1));
    assign load_ready  = !pend;
    assign accept      = load_valid && !pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index      <= '0;
            display    <= '0;
            shadow     <= '0;
            pend       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_start;
            if (tick) begin
                index <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
            end
            // accept and transfer are exclusive: accept needs pend=0, transfer needs pend=1
            if (frame_start && pend) begin
                display <= shadow;
                pend    <= 1'b0;
            end else if (accept) begin
                shadow <= value_in;
                pend   <= 1'b1;
            end
        end
    end

    // zero_from[i]: nibble i and every more-significant nibble are zero
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run && (display[4*i +: 4] == 4'h0);
            zero_from[i] = run;
        end
    end

    assign blanked    = blank_lz && (index != '0) && zero_from[index];
    assign nibble_out = display[{index, 2'b00} +: 4];
    assign digit_en_n = blanked ? '1 : ~(NUM_DIGITS'(1) << index);

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - scoreboard bench for hex_display_scanner
module tb_hex_display_scanner;

    localparam int N = 8;
    localparam int D = 4;
    localparam int F = N * D;

    typedef struct {
        logic [31:0] value;
        int          ready_at;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [31:0]   value_in = '0;
    logic          blank_lz = 1'b0;
    logic          load_ready;
    logic [3:0]    nibble_out;
    logic [N-1:0]  digit_en_n;
    logic          frame_done;

    entry_t        sb_q[$];
    logic [31:0]   exp_disp = '0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    hex_display_scanner #(
        .NUM_DIGITS(N),
        .SCAN_DIV  (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .value_in  (value_in),
        .load_ready(load_ready),
        .blank_lz  (blank_lz),
        .nibble_out(nibble_out),
        .digit_en_n(digit_en_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: advance the reference model past the edge, then compare outputs.
    always @(posedge clk) begin
        int          d;
        logic        blk;
        logic [N-1:0] exp_en;
        #1;
        if (!rst_n) begin
            cyc      = 0;
            exp_disp = '0;
            sb_q.delete();
        end else begin
            cyc = cyc + 1;
            if (cyc % F == 0 && sb_q.size() > 0 && sb_q[0].ready_at <= cyc) begin
                exp_disp = sb_q[0].value;
                void'(sb_q.pop_front());
            end
        end
        d      = (cyc / D) % N;
        blk    = blank_lz && d > 0 && ((exp_disp >> (4 * d)) == 32'd0);
        exp_en = '1;
        if (!blk) exp_en[d] = 1'b0;
        check("nibble_out", {28'd0, nibble_out}, {28'd0, exp_disp[4*d +: 4]});
        check("digit_en_n", {24'd0, digit_en_n}, {24'd0, exp_en});
        check("frame_done", {31'd0, frame_done}, {31'd0, (cyc > 0 && cyc % F == 0)});
        check("load_ready", {31'd0, load_ready}, {31'd0, (sb_q.size() == 0)});
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a negedge: drives inputs for the next edge and predicts acceptance.
    task automatic offer(input logic valid, input logic [31:0] value);
        int k;
        load_valid = valid;
        value_in   = value;
        if (valid && rst_n && sb_q.size() == 0) begin
            k = cyc + 1;
            sb_q.push_back('{value: value, ready_at: ((k / F) + 1) * F});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            offer(1'b0, 32'd0);
        end
    endtask

    task automatic load(input logic [31:0] value);
        step();
        offer(1'b1, value);
        step();
        offer(1'b0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        step();
        offer(1'b0, 32'd0);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout cyc=%0d got=none expected=condition", name, cyc);
    endtask

    initial begin
        bit hit;
        do_reset(3);
        load(32'h1234ABCD);
        idle(2 * F + 5);

        // backpressure: second value offered while the first is still pending
        load(32'h11111111);
        repeat (6) begin
            step();
            offer(1'b1, 32'h22222222);
        end
        step();
        offer(1'b0, 32'd0);
        idle(F + 4);

        blank_lz = 1'b1;
        load(32'h000000A5);
        idle(2 * F + 2);
        load(32'h00000000);
        idle(2 * F + 2);
        blank_lz = 1'b0;

        // coincidence: accept exactly on the frame_start edge
        hit = 0;
        for (int i = 0; i < 4 * F && !hit; i++) begin
            step();
            if (sb_q.size() == 0 && (cyc + 1) % F == 0) begin
                offer(1'b1, 32'hCAFEF00D);
                hit = 1;
            end else begin
                offer(1'b0, 32'd0);
            end
        end
        if (!hit) timeout("coincidence_align");
        idle(2 * F + 3);

        for (int i = 0; i < 400; i++) begin
            step();
            if ($urandom_range(39) == 0) blank_lz = ~blank_lz;
            offer($urandom_range(5) == 0,
                  ($urandom_range(2) == 0) ? ($urandom() & 32'h00000FFF) : $urandom());
        end
        idle(F + 2);

        // mid-frame reset with a pending value at digit 5
        blank_lz = 1'b0;
        hit = 0;
        for (int i = 0; i < 4 * F && !hit; i++) begin
            step();
            if (sb_q.size() == 0 && cyc % F == 1) begin
                offer(1'b1, 32'hDEADBEEF);
                hit = 1;
            end else begin
                offer(1'b0, 32'd0);
            end
        end
        if (!hit) timeout("pend_align");
        hit = 0;
        for (int i = 0; i < 2 * F && !hit; i++) begin
            step();
            offer(1'b0, 32'd0);
            if ((cyc / D) % N == 5) hit = 1;
        end
        if (!hit) timeout("index5_align");
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        idle(2 * F + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
